// File: rtl/cgra_launch_ctrl.sv
// cgra_launch_ctrl: registered launch sequencer for the TCAD array (config, SPM load, run, wait, done).
// Define LAUNCH_PERF_CNT_EN to report the launch duration on perf_cycles; otherwise perf_cycles is 0.
module cgra_launch_ctrl #(
   parameter int HC_W       = 832,
   parameter int A_W        = 10,
   parameter int D_W        = 32,
   parameter int CFG_CYCLES = 3,
   parameter int RC_W       = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic [HC_W-1:0]    cfg_word,
   input  logic [A_W-1:0]     load_base,
   input  logic [A_W:0]       load_len,
   input  logic [RC_W-1:0]    run_cycles,
   input  logic               src_valid,
   input  logic [D_W-1:0]     src_data,
   output logic               src_ready,
   output logic               init,
   output logic               run,
   output logic [HC_W-1:0]    host_controller,
   output logic [A_W+D_W+1:0] ex_bus,
   output logic               busy,
   output logic               done,
   output logic [31:0]        perf_cycles
);
   typedef enum logic [2:0] {IDLE, CONFIG, LOAD, RUN, WAIT, DONE} state_t;
   state_t          state;
   logic [RC_W-1:0] cnt, rc;
   logic [A_W:0]    rem;
   logic [A_W-1:0]  ptr, ex_addr;
   logic [D_W-1:0]  ex_data;
   logic            ex_wen;
   // the block only ever writes the scratchpad, so ex_ren is hard zero
   assign ex_bus = {ex_wen, 1'b0, ex_addr, ex_data};
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state           <= IDLE;
         cnt             <= '0;
         rc              <= '0;
         rem             <= '0;
         ptr             <= '0;
         ex_addr         <= '0;
         ex_data         <= '0;
         ex_wen          <= 1'b0;
         src_ready       <= 1'b0;
         init            <= 1'b0;
         run             <= 1'b0;
         busy            <= 1'b0;
         done            <= 1'b0;
         host_controller <= '0;
      end else if (abort) begin
         state     <= IDLE;
         init      <= 1'b0;
         run       <= 1'b0;
         ex_wen    <= 1'b0;
         src_ready <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         run    <= 1'b0;
         ex_wen <= 1'b0;
         done   <= 1'b0;
         case (state)
            IDLE: if (start) begin
               state           <= CONFIG;
               init            <= 1'b1;
               busy            <= 1'b1;
               host_controller <= cfg_word;
               ptr             <= load_base;
               rem             <= load_len;
               rc              <= run_cycles;
               cnt             <= RC_W'(CFG_CYCLES);
            end
            CONFIG: begin
               cnt <= cnt - 1'b1;
               if (cnt == RC_W'(1)) begin
                  init      <= 1'b0;
                  src_ready <= rem != '0;
                  run       <= rem == '0;
                  state     <= rem != '0 ? LOAD : RUN;
               end
            end
            // the last write and the run pulse land in the same cycle
            LOAD: if (src_valid && src_ready) begin
               ex_wen  <= 1'b1;
               ex_addr <= ptr;
               ex_data <= src_data;
               ptr     <= ptr + 1'b1;
               rem     <= rem - 1'b1;
               if (rem == (A_W+1)'(1)) begin
                  src_ready <= 1'b0;
                  run       <= 1'b1;
                  state     <= RUN;
               end
            end
            RUN: begin
               cnt   <= rc;
               done  <= rc == '0;
               state <= rc != '0 ? WAIT : DONE;
            end
            WAIT: begin
               cnt <= cnt - 1'b1;
               if (cnt == RC_W'(1)) begin
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            DONE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
`ifdef LAUNCH_PERF_CNT_EN
   logic [31:0] pc, pc_inc;
   assign pc_inc = pc + 32'(pc != '1);
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         pc          <= '0;
         perf_cycles <= '0;
      end else if (state == IDLE) pc <= '0;
      else if (!abort) begin
         pc <= pc_inc;
         if (state == DONE) perf_cycles <= pc_inc;
      end
`else
   assign perf_cycles = '0;
`endif
endmodule

// File: doc/cgra_launch_ctrl.md
Name: cgra_launch_ctrl

Overview:
Launch sequencer sitting between the host and the TCAD array top. On a start command it latches a full host_controller configuration word and drives init for a fixed number of cycles. It then streams a data block into the scratchpad over ex_bus, pulses run, waits a programmed number of execution cycles and signals done. It replaces hand-sequenced init/run/ex_bus driving with one registered, repeatable launch.

Parameters:
HC_W, 832, width of host_controller (SPM config bits + 4 config buffers)
A_W, 10, ex_bus address width
D_W, 32, ex_bus data width
CFG_CYCLES, 3, cycles init is held high (1..15)
RC_W, 16, width of run-cycle counter

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  launch request, sampled only in IDLE
abort  input  1  synchronous abort, any state -> IDLE
cfg_word  input  HC_W  configuration captured on accepted start
load_base  input  A_W  first SPM address of the data block, captured on start
load_len  input  A_W+1  number of words to write (0..2^A_W), captured on start
run_cycles  input  RC_W  execution cycles to wait after the run pulse, captured on start
src_valid  input  1  data beat valid
src_data  input  D_W  data beat
src_ready  output  1  beat accepted when src_valid & src_ready
init  output  1  to array init
run  output  1  to array run
host_controller  output  HC_W  to array host_controller
ex_bus  output  2+A_W+D_W  {ex_wen, ex_ren, ex_addr, ex_data}
busy  output  1  high in any state except IDLE
done  output  1  one-cycle completion pulse
perf_cycles  output  32  launch duration, see Optional Feature

Behaviour:
- All outputs are registered. Reset values: all outputs 0, including host_controller. State = IDLE.
- States: IDLE, CONFIG, LOAD, RUN, WAIT, DONE.
- IDLE, start=1 at edge T: latch cfg_word, load_base, load_len and run_cycles -> CONFIG. init=1 and host_controller=latched cfg from T+1 for exactly CFG_CYCLES cycles.
- CONFIG: init falls when the state exits. Next state is LOAD if load_len!=0, else RUN.
- host_controller keeps the latched value after CONFIG until the next accepted start. It is not cleared at DONE and not cleared by abort.
- LOAD: src_ready=1.
  - On each accepted beat k (0-based), the next cycle drives ex_wen=1, ex_ren=0, ex_addr=(load_base+k) mod 2^A_W, ex_data=src_data.
  - Cycles with no accepted beat drive ex_wen=0 and hold addr/data.
  - After beat load_len-1 is accepted, src_ready drops the same edge and the state goes to RUN.
  - Address wraps with no error.
- RUN: run=1 for exactly one cycle; ex_wen=0. Next state is WAIT if run_cycles!=0, else DONE.
- WAIT: counter loads run_cycles and decrements each cycle. Exit to DONE when it reaches 1, so WAIT lasts run_cycles cycles.
- DONE: done=1 for one cycle -> IDLE. busy is still 1 during DONE.
- start outside IDLE is ignored. start in the DONE cycle is ignored; it must be re-presented in IDLE.
- abort has priority over every transition. Next edge: IDLE, with init, run, ex_wen, src_ready=0 and busy=0. No done pulse. A partially loaded block is not rolled back.
- abort and start together in IDLE: abort wins and start is dropped.
- ex_ren is always 0; this block never reads over ex_bus.
- rst mid-operation: immediate return to reset values, including host_controller=0.

Optional Feature:
LAUNCH_PERF_CNT_EN
- Defined:
  - A 32-bit counter clears on accepted start and increments every busy cycle.
  - At DONE, perf_cycles is updated with the count and holds until the next DONE.
  - Saturates at 0xFFFFFFFF.
  - Abort does not update perf_cycles.
- Undefined: perf_cycles is tied to 0 and no counter logic is present.

Test Plan:
- CFG_CYCLES=3, cfg_word=pattern 0xA5..., load_len=0, run_cycles=0, start at T -> init high T+1..T+3; host_controller=pattern from T+1; run high T+4; done T+5; busy T+1..T+5.
- load_base=0, load_len=10, src_data=1..10 with src_valid always high -> ex_wen high for 10 consecutive cycles, addr 0..9, data 1..10; then one run pulse.
- Same as above but src_valid low on every other cycle -> still 10 writes, addr 0..9 in order, ex_wen low on stall cycles, no lost or duplicated beats.
- load_base=1022, load_len=4 -> addresses 1022, 1023, 0, 1 with no error.
- run_cycles=5 -> exactly 5 WAIT cycles between the run pulse and done. With LAUNCH_PERF_CNT_EN, perf_cycles = CFG_CYCLES+load_len+1+5+1.
- abort asserted on the 3rd LOAD beat -> IDLE next cycle, src_ready=0, no done, host_controller retained. A new start then completes normally. rst during WAIT -> all outputs 0 immediately.
